// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction-fetch and load/store ports sharing
// one single-ported, registered-read memory; one access in flight at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [3:0]  d_wstrb,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req and its payload stable until its ack
  // pulse; ack is a one-cycle strobe qualifying that port's rdata/err.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_gnt_d_q, last_gnt_d_d;
  logic        gnt_d_q, gnt_d_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        i_ack_q, i_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic        i_err_q, i_err_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;

  logic        elig_i, elig_d, pick_d, sel_err;
  logic [31:0] sel_addr, resp_data;

  // A port's request is ignored in the cycle its ack is showing, since the
  // requester has not yet had a chance to drop or update it.
  assign elig_i    = i_req & ~i_ack_q;
  assign elig_d    = d_req & ~d_ack_q;
  assign pick_d    = elig_d & (~elig_i | ~last_gnt_d_q);
  assign sel_addr  = pick_d ? d_addr : i_addr;
  assign sel_err   = (sel_addr[1:0] != 2'b00) | (|sel_addr[31:ADDR_WIDTH]);
  assign resp_data = (err_q | wr_q) ? 32'h0 : mem_rdata;

  always_comb begin
    state_d      = state_q;
    last_gnt_d_d = last_gnt_d_q;
    gnt_d_d      = gnt_d_q;
    err_d        = err_q;
    wr_d         = wr_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    i_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    i_err_d      = i_err_q;
    d_ack_d      = 1'b0;
    d_rdata_d    = d_rdata_q;
    d_err_d      = d_err_q;
    case (state_q)
      S_IDLE: begin
        if (elig_i | elig_d) begin
          gnt_d_d      = pick_d;
          last_gnt_d_d = pick_d;
          err_d        = sel_err;
          wr_d         = pick_d & d_we;
          mem_we_d     = 4'b0000;
          if (!sel_err) begin
            mem_addr_d  = sel_addr;
            mem_we_d    = (pick_d & d_we) ? d_wstrb : 4'b0000;
            mem_wdata_d = d_wdata;
          end
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_we_d = 4'b0000;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (gnt_d_q) begin
          d_ack_d   = 1'b1;
          d_rdata_d = resp_data;
          d_err_d   = err_q;
        end else begin
          i_ack_d   = 1'b1;
          i_rdata_d = resp_data;
          i_err_d   = err_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_gnt_d_q <= 1'b1;
      gnt_d_q      <= 1'b0;
      err_q        <= 1'b0;
      wr_q         <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_we_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      i_ack_q      <= 1'b0;
      i_rdata_q    <= 32'h0;
      i_err_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      d_rdata_q    <= 32'h0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_d_q <= last_gnt_d_d;
      gnt_d_q      <= gnt_d_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      i_rdata_q    <= i_rdata_d;
      i_err_q      <= i_err_d;
      d_ack_q      <= d_ack_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory, scoreboard queues per
// port, and a negedge monitor that checks every ack against expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic        d_we = 1'b0;
  logic [3:0]  d_wstrb = 4'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cycles = 0;
  logic [3:0] last_we = 4'h0;

  logic [32:0] exp_i_q[$];
  logic [32:0] exp_d_q[$];
  logic        exp_ord_q[$];

  logic [31:0] mem [0:4095];
  bit          init_done = 1'b0;

  mem_arbiter #(.ADDR_WIDTH(14)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory model: byte-enabled write, one-cycle registered read
  always @(posedge clk) begin
    if (!init_done) begin
      for (int k = 0; k < 4096; k++) mem[k] <= 32'h0;
      mem[0]  <= 32'h00100513;
      mem[1]  <= 32'h55667788;
      mem[2]  <= 32'hCAFEF00D;
      mem[3]  <= 32'h0BADC0DE;
      mem[16] <= 32'h11223344;
      mem[32] <= 32'hDEADBEEF;
      init_done <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[13:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we != 4'h0) begin
        we_cycles++;
        last_we = mem_we;
        chk("mem_we_only_in_access", {30'h0, dbg_state}, 32'd1);
      end
      if (i_ack || d_ack) begin
        chk("acks_exclusive", {31'h0, i_ack & d_ack}, 32'd0);
        if (exp_ord_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          logic o;
          o = exp_ord_q.pop_front();
          chk("ack_port_order", {31'h0, d_ack}, {31'h0, o});
        end
      end
      if (i_ack) begin
        if (exp_i_q.size() == 0) chk("i_unexpected", 32'd1, 32'd0);
        else begin
          logic [32:0] e;
          e = exp_i_q.pop_front();
          chk("i_err", {31'h0, i_err}, {31'h0, e[32]});
          chk("i_rdata", i_rdata, e[31:0]);
        end
      end
      if (d_ack) begin
        if (exp_d_q.size() == 0) chk("d_unexpected", 32'd1, 32'd0);
        else begin
          logic [32:0] e;
          e = exp_d_q.pop_front();
          chk("d_err", {31'h0, d_err}, {31'h0, e[32]});
          chk("d_rdata", d_rdata, e[31:0]);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_we"}, {28'h0, mem_we}, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_acks"}, {30'h0, i_ack, d_ack}, 32'h0);
    chk({tag, "_errs"}, {30'h0, i_err, d_err}, 32'h0);
    chk({tag, "_i_rdata"}, i_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
  endtask

  // waits at negedges for the port's ack; returns cycles taken
  task automatic wait_ack(input bit port_d, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port_d ? d_ack : i_ack) && n < 20);
    if (!(port_d ? d_ack : i_ack)) chk("ack_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_i(input logic [31:0] addr, input logic e_err, input logic [31:0] e_data,
                      output int lat);
    exp_i_q.push_back({e_err, e_data});
    exp_ord_q.push_back(1'b0);
    @(negedge clk);
    i_req = 1'b1; i_addr = addr;
    wait_ack(1'b0, lat);
    i_req = 1'b0;
  endtask

  task automatic do_d(input logic [31:0] addr, input logic we, input logic [3:0] strb,
                      input logic [31:0] wdata, input logic e_err, input logic [31:0] e_data,
                      output int lat);
    exp_d_q.push_back({e_err, e_data});
    exp_ord_q.push_back(1'b1);
    @(negedge clk);
    d_req = 1'b1; d_addr = addr; d_we = we; d_wstrb = strb; d_wdata = wdata;
    wait_ack(1'b1, lat);
    d_req = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc, acks, w0, m;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // conflict: both held; grants I, D, I, D, four acks in 12 cycles
    exp_i_q.push_back({1'b0, 32'hCAFEF00D}); exp_i_q.push_back({1'b0, 32'hCAFEF00D});
    exp_d_q.push_back({1'b0, 32'h0BADC0DE}); exp_d_q.push_back({1'b0, 32'h0BADC0DE});
    exp_ord_q.push_back(1'b0); exp_ord_q.push_back(1'b1);
    exp_ord_q.push_back(1'b0); exp_ord_q.push_back(1'b1);
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_addr = 32'hC; d_we = 1'b0;
    cyc = 0; acks = 0;
    while (acks < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (i_ack || d_ack) acks++;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("conflict_cycles", cyc, 32'd12);

    // single fetch
    do_i(32'h0, 1'b0, 32'h00100513, lat);
    chk("fetch_latency", lat, 32'd3);

    // byte write then read back
    w0 = we_cycles;
    do_d(32'h40, 1'b1, 4'b0010, 32'h0000AB00, 1'b0, 32'h0, lat);
    chk("write_latency", lat, 32'd3);
    chk("write_we_cycles", we_cycles - w0, 32'd1);
    chk("write_we_value", {28'h0, last_we}, 32'h2);
    chk("mem_word_0x40", mem[16], 32'h1122AB44);
    do_d(32'h40, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h1122AB44, lat);

    // zero-strobe write: legal, nothing changes
    do_d(32'h40, 1'b1, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h0, lat);
    chk("zero_strobe_word", mem[16], 32'h1122AB44);

    // error cases
    w0 = we_cycles;
    do_d(32'h42, 1'b1, 4'b1111, 32'h99999999, 1'b1, 32'h0, lat);
    chk("err_write_no_we", we_cycles - w0, 32'd0);
    chk("err_write_word", mem[16], 32'h1122AB44);
    do_i(32'h4000, 1'b1, 32'h0, lat);
    do_i(32'h2, 1'b1, 32'h0, lat);
    do_d(32'h10000000, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0, lat);

    // back-to-back on the data port with a new address held across the ack
    exp_d_q.push_back({1'b0, 32'h00100513}); exp_d_q.push_back({1'b0, 32'h55667788});
    exp_ord_q.push_back(1'b1); exp_ord_q.push_back(1'b1);
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h0; d_we = 1'b0;
    wait_ack(1'b1, lat);
    d_addr = 32'h4;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!busy && m < 20);
    n_checks++;
    if (m < 2) begin
      n_fail++;
      $display("FAIL b2b_regrant_gap: got %0d cycles required at least 2", m);
    end
    wait_ack(1'b1, lat);
    d_req = 1'b0;

    // reset during the ACCESS cycle of a write to 0x80
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h80; d_we = 1'b1; d_wstrb = 4'hF; d_wdata = 32'h12345678;
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (!busy && m < 20);
    chk("pre_reset_we", {28'h0, mem_we}, 32'hF);
    rst = 1'b1;
    #1;
    chk_reset_vals("midreset");
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("word_0x80_kept", mem[32], 32'hDEADBEEF);
    do_d(32'h80, 1'b0, 4'b0000, 32'h0, 1'b0, 32'hDEADBEEF, lat);

    repeat (4) @(negedge clk);
    chk("pending_expectations", exp_i_q.size() + exp_d_q.size() + exp_ord_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
